// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic queue sensor.
// It holds the light encoding, the protocol error bit indices, the arrival
// LFSR constants and the light-transition legality helper.
package traffic_pkg;

    typedef enum logic [1:0] {
        RED    = 2'b00,
        YELLOW = 2'b01,
        GREEN  = 2'b11
    } light_t;

    // The one two-bit code the controller must never drive
    localparam logic [1:0] LIGHT_INVALID = 2'b10;

    localparam int ERR_CONFLICT   = 0;
    localparam int ERR_ENCODING   = 1;
    localparam int ERR_TRANSITION = 2;

    // Fibonacci taps 16,14,13,11 expressed as a mask over bits [15:0]
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Holding a light is always legal; the only legal changes follow the light cycle
    function automatic logic legal_transition(input light_t prev, input logic [1:0] cur);
        return (cur == prev)
            || (prev == RED    && cur == GREEN)
            || (prev == GREEN  && cur == YELLOW)
            || (prev == YELLOW && cur == RED);
    endfunction

endpackage

// File: rtl/road_queue.sv
// One road's vehicle queue.
// It contains the saturating count, the green-time discharge timer, the
// sticky overflow flag and the registered sensor request.
module road_queue
    import traffic_pkg::*;
#(
    parameter int QUEUE_DEPTH        = 15,
    parameter int SENSOR_THRESHOLD   = 1,
    parameter int DISCHARGE_INTERVAL = 4,
    localparam int CW = $clog2(QUEUE_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          arrival,
    input  logic [1:0]    light,
    output logic [CW-1:0] count,
    output logic          sensor,
    output logic          overflow
);

    localparam int TW = (DISCHARGE_INTERVAL > 1) ? $clog2(DISCHARGE_INTERVAL) : 1;

    logic [CW-1:0] count_q, count_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          overflow_q, overflow_d;
    logic          sensor_q, sensor_d;
    logic          is_green, timer_wrap, discharge;

    // The timer only advances while green, so no partial credit survives a red
    // or yellow phase. Arrival and discharge in the same cycle cancel out.
    always_comb begin
        is_green   = (light == GREEN);
        timer_wrap = is_green && (timer_q == TW'(DISCHARGE_INTERVAL - 1));
        discharge  = timer_wrap && (count_q != '0);

        timer_d = '0;
        if (is_green && !timer_wrap) begin
            timer_d = timer_q + 1'b1;
        end

        count_d    = count_q;
        overflow_d = overflow_q;
        if (arrival && !discharge) begin
            if (count_q == CW'(QUEUE_DEPTH)) begin
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end else if (discharge && !arrival) begin
            count_d = count_q - 1'b1;
        end

        sensor_d = (count_d >= CW'(SENSOR_THRESHOLD)) && (light == RED);
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q    <= '0;
            timer_q    <= '0;
            overflow_q <= 1'b0;
            sensor_q   <= 1'b0;
        end else begin
            count_q    <= count_d;
            timer_q    <= timer_d;
            overflow_q <= overflow_d;
            sensor_q   <= sensor_d;
        end
    end

    assign count    = count_q;
    assign sensor   = sensor_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/traffic_queue_sensor.sv
// Road-side model of the traffic light controller's environment.
// It holds two road queues feeding the sensor requests, plus a protocol monitor
// that watches the light outputs and latches sticky error bits.
// Optional feature macro: ARRIVAL_LFSR_EN adds pseudo-random internal arrivals
// from a 16-bit LFSR, ORed with the external arrival ports.
module traffic_queue_sensor
    import traffic_pkg::*;
#(
    parameter int QUEUE_DEPTH        = 15,
    parameter int SENSOR_THRESHOLD   = 1,
    parameter int DISCHARGE_INTERVAL = 4,
    localparam int CW = $clog2(QUEUE_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          main_arrival,
    input  logic          side_arrival,
    input  logic [1:0]    main_road_light,
    input  logic [1:0]    side_road_light,
    output logic          main_road_sensor,
    output logic          side_road_sensor,
    output logic [CW-1:0] main_queue_count,
    output logic [CW-1:0] side_queue_count,
    output logic          main_overflow,
    output logic          side_overflow,
    output logic [2:0]    protocol_error
);

    logic main_arr, side_arr;

`ifdef ARRIVAL_LFSR_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Shift left and feed the XOR of the tap bits back into bit 0
    always_comb begin
        lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    end

    // LFSR register, reseeded on reset
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign main_arr = main_arrival | (lfsr_q[7:0]  < 8'd64);
    assign side_arr = side_arrival | (lfsr_q[15:8] < 8'd32);
`else
    assign main_arr = main_arrival;
    assign side_arr = side_arrival;
`endif

    road_queue #(
        .QUEUE_DEPTH        (QUEUE_DEPTH),
        .SENSOR_THRESHOLD   (SENSOR_THRESHOLD),
        .DISCHARGE_INTERVAL (DISCHARGE_INTERVAL)
    ) u_main (
        .clk      (clk),
        .reset    (reset),
        .arrival  (main_arr),
        .light    (main_road_light),
        .count    (main_queue_count),
        .sensor   (main_road_sensor),
        .overflow (main_overflow)
    );

    road_queue #(
        .QUEUE_DEPTH        (QUEUE_DEPTH),
        .SENSOR_THRESHOLD   (SENSOR_THRESHOLD),
        .DISCHARGE_INTERVAL (DISCHARGE_INTERVAL)
    ) u_side (
        .clk      (clk),
        .reset    (reset),
        .arrival  (side_arr),
        .light    (side_road_light),
        .count    (side_queue_count),
        .sensor   (side_road_sensor),
        .overflow (side_overflow)
    );

    light_t     prev_main_q, prev_main_d;
    light_t     prev_side_q, prev_side_d;
    logic [2:0] error_q, error_d;
    logic [2:0] error_new;
    logic       main_valid, side_valid;

    // Detect protocol errors. An invalid code is flagged only as an encoding
    // error and is never stored as the previous light.
    always_comb begin
        main_valid = (main_road_light != LIGHT_INVALID);
        side_valid = (side_road_light != LIGHT_INVALID);

        error_new                 = '0;
        error_new[ERR_CONFLICT]   = (main_road_light != RED) && (side_road_light != RED);
        error_new[ERR_ENCODING]   = !main_valid || !side_valid;
        error_new[ERR_TRANSITION] = (main_valid && !legal_transition(prev_main_q, main_road_light))
                                 || (side_valid && !legal_transition(prev_side_q, side_road_light));

        error_d     = error_q | error_new;
        prev_main_d = main_valid ? light_t'(main_road_light) : prev_main_q;
        prev_side_d = side_valid ? light_t'(side_road_light) : prev_side_q;
    end

    // Monitor registers; reset returns the previous lights to RED
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_main_q <= RED;
            prev_side_q <= RED;
            error_q     <= '0;
        end else begin
            prev_main_q <= prev_main_d;
            prev_side_q <= prev_side_d;
            error_q     <= error_d;
        end
    end

    assign protocol_error = error_q;

endmodule

// File: tb/tb_traffic_queue_sensor.sv
// Self-checking bench for traffic_queue_sensor (default build, no LFSR).
// A behavioural road model pushes the expected output vector when each cycle
// is driven; the test tasks pop and compare after the clock edge.
module tb_traffic_queue_sensor;

    localparam logic [1:0] R   = 2'b00;
    localparam logic [1:0] Y   = 2'b01;
    localparam logic [1:0] G   = 2'b11;
    localparam logic [1:0] BAD = 2'b10;

    logic       clk = 1'b0;
    logic       reset;
    logic       main_arrival, side_arrival;
    logic [1:0] main_road_light, side_road_light;
    logic       main_road_sensor, side_road_sensor;
    logic [3:0] main_queue_count, side_queue_count;
    logic       main_overflow, side_overflow;
    logic [2:0] protocol_error;

    logic [14:0] obs;
    logic [14:0] sb[$];
    int checks = 0;
    int errors = 0;

    int m_cnt, m_tmr, m_ovf, m_sen;
    int s_cnt, s_tmr, s_ovf, s_sen;
    int err, prev_m, prev_s;

    traffic_queue_sensor dut (
        .clk              (clk),
        .reset            (reset),
        .main_arrival     (main_arrival),
        .side_arrival     (side_arrival),
        .main_road_light  (main_road_light),
        .side_road_light  (side_road_light),
        .main_road_sensor (main_road_sensor),
        .side_road_sensor (side_road_sensor),
        .main_queue_count (main_queue_count),
        .side_queue_count (side_queue_count),
        .main_overflow    (main_overflow),
        .side_overflow    (side_overflow),
        .protocol_error   (protocol_error)
    );

    always #5 clk = ~clk;

    assign obs = {main_queue_count, side_queue_count, main_road_sensor, side_road_sensor,
                  main_overflow, side_overflow, protocol_error};

    // Reference model of one road for one clock edge
    task automatic model_road(input int a, input int l, inout int cnt, inout int tmr,
                              inout int ovf, inout int sen);
        bit green, fire, dis;
        green = (l == 3);
        fire  = green && (tmr == 3);
        dis   = fire && (cnt > 0);
        if (!green || fire) tmr = 0;
        else tmr = tmr + 1;
        if (a != 0 && !dis) begin
            if (cnt == 15) ovf = 1;
            else cnt = cnt + 1;
        end else if (dis && a == 0) begin
            cnt = cnt - 1;
        end
        sen = (cnt >= 1 && l == 0) ? 1 : 0;
    endtask

    function automatic bit legal(input int p, input int c);
        return (p == c) || (p == 0 && c == 3) || (p == 3 && c == 1) || (p == 1 && c == 0);
    endfunction

    // Drive one cycle, update the model, push the expectation, step past the edge
    task automatic drive(input bit rst, input bit ma, input bit sa,
                         input logic [1:0] ml, input logic [1:0] sl);
        reset = rst; main_arrival = ma; side_arrival = sa;
        main_road_light = ml; side_road_light = sl;
        if (rst) begin
            m_cnt = 0; m_tmr = 0; m_ovf = 0; m_sen = 0;
            s_cnt = 0; s_tmr = 0; s_ovf = 0; s_sen = 0;
            err = 0; prev_m = 0; prev_s = 0;
        end else begin
            model_road(int'(ma), int'(ml), m_cnt, m_tmr, m_ovf, m_sen);
            model_road(int'(sa), int'(sl), s_cnt, s_tmr, s_ovf, s_sen);
            if (ml != R && sl != R) err = err | 1;
            if (ml == BAD || sl == BAD) err = err | 2;
            if (ml != BAD && !legal(prev_m, int'(ml))) err = err | 4;
            if (sl != BAD && !legal(prev_s, int'(sl))) err = err | 4;
            if (ml != BAD) prev_m = int'(ml);
            if (sl != BAD) prev_s = int'(sl);
        end
        sb.push_back({4'(m_cnt), 4'(s_cnt), 1'(m_sen), 1'(s_sen), 1'(m_ovf), 1'(s_ovf), 3'(err)});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [14:0] e;
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 1, G, G);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("[TB] FAIL reset_%0d actual %h required %h", i, obs, e);
            end
        end
        checks++;
        if (obs !== 15'h0) begin
            errors++;
            $display("[TB] FAIL reset_zero actual %h required 0000", obs);
        end
    endtask

    task automatic test_side_fill();
        logic [14:0] e;
        for (int i = 1; i <= 3; i++) begin
            drive(0, 0, 1, R, R);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("[TB] FAIL side_fill_%0d actual %h required %h", i, obs, e);
            end
            checks++;
            if (side_road_sensor !== 1'b1) begin
                errors++;
                $display("[TB] FAIL side_sensor_%0d actual %b required 1", i, side_road_sensor);
            end
        end
        checks++;
        if (side_queue_count !== 4'd3) begin
            errors++;
            $display("[TB] FAIL side_count3 actual %0d required 3", side_queue_count);
        end
    endtask

    task automatic test_discharge();
        logic [14:0] e;
        for (int i = 1; i <= 12; i++) begin
            drive(0, 0, 0, R, G);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("[TB] FAIL discharge_%0d actual %h required %h", i, obs, e);
            end
            checks++;
            if (side_queue_count !== 4'(3 - i / 4) || side_road_sensor !== 1'b0) begin
                errors++;
                $display("[TB] FAIL discharge_count_%0d actual %0d/%b required %0d/0",
                         i, side_queue_count, side_road_sensor, 3 - i / 4);
            end
        end
        drive(0, 0, 0, R, Y); void'(sb.pop_front());
        drive(0, 0, 0, R, R); void'(sb.pop_front());
    endtask

    task automatic test_saturate();
        logic [14:0] e;
        logic [1:0]  ml;
        for (int i = 1; i <= 20; i++) begin
            ml = (i <= 3) ? G : (i == 4) ? Y : R;
            drive(0, (i <= 17), 0, ml, R);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("[TB] FAIL saturate_%0d actual %h required %h", i, obs, e);
            end
            if (i >= 17) begin
                checks++;
                if (main_queue_count !== 4'd15 || main_overflow !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL saturate_hold_%0d actual %0d/%b required 15/1",
                             i, main_queue_count, main_overflow);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [14:0] e;
        logic [1:0]  sl;
        for (int i = 1; i <= 11; i++) begin
            sl = (i <= 5) ? R : (i <= 10) ? G : Y;
            drive(0, 0, (i <= 5 || i >= 9) && i != 11, R, sl);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("[TB] FAIL b2b_%0d actual %h required %h", i, obs, e);
            end
            if (i == 9) begin
                checks++;
                if (side_queue_count !== 4'd5 || side_overflow !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL b2b_cancel actual %0d/%b required 5/0",
                             side_queue_count, side_overflow);
                end
            end
        end
        drive(0, 0, 0, R, R); void'(sb.pop_front());
    endtask

    task automatic test_protocol();
        logic [14:0] e;
        logic [1:0]  mls[8] = '{G, Y, R, G, R, BAD, R, R};
        logic [1:0]  sls[8] = '{G, Y, R, R, R, R,   R, R};
        logic [2:0]  want[8] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b101, 3'b111, 3'b111, 3'b111};
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 0, mls[i], sls[i]);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("[TB] FAIL protocol_%0d actual %h required %h", i, obs, e);
            end
            checks++;
            if (protocol_error !== want[i]) begin
                errors++;
                $display("[TB] FAIL protocol_bits_%0d actual %b required %b", i, protocol_error, want[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [14:0] e;
        logic [1:0]  ml;
        drive(1, 0, 0, R, R); void'(sb.pop_front());
        for (int i = 1; i <= 9; i++) begin
            ml = (i <= 7) ? R : G;
            drive(0, (i <= 7), 1, ml, R);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("[TB] FAIL pre_reset_%0d actual %h required %h", i, obs, e);
            end
        end
        checks++;
        if (main_queue_count !== 4'd7) begin
            errors++;
            $display("[TB] FAIL main_count7 actual %0d required 7", main_queue_count);
        end
        drive(1, 1, 1, G, R);
        e = sb.pop_front();
        checks++;
        if (obs !== 15'h0 || obs !== e) begin
            errors++;
            $display("[TB] FAIL reset_mid actual %h required %h", obs, e);
        end
        for (int i = 0; i < 3; i++) begin
            ml = (i == 0) ? G : (i == 1) ? Y : R;
            drive(0, 0, 0, ml, R);
            e = sb.pop_front();
            checks++;
            if (obs !== e || protocol_error !== 3'b000) begin
                errors++;
                $display("[TB] FAIL post_reset_%0d actual %h required %h", i, obs, e);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        main_arrival = 1'b0;
        side_arrival = 1'b0;
        main_road_light = R;
        side_road_light = R;
        test_reset();
        test_side_fill();
        test_discharge();
        test_saturate();
        test_back_to_back();
        test_protocol();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
